wb_ram_arbiter: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter in front of the shared 1024x32 SRAM Wishbone slave (registered ack, `ack <= cyc & stb`).
- Lets the FazyRV instruction bus (master 0) and data bus (master 1) share the single SRAM macro.
- Round-robin grant and one transaction per grant.
- Single-cycle strobe toward the slave, so the registered-ack slave never performs a duplicate access.
- Bounded-wait timeout returns an error to the requester.

---
 rtl/wb_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
//   Two-master to one-slave Wishbone classic arbiter in front of a shared
//   registered-ack SRAM slave. Master 0 is the instruction bus, master 1 the
//   data bus. Grants alternate round-robin, one transaction per grant, and
//   the slave sees a single-cycle strobe per transaction. A bounded wait
//   aborts with an error pulse to the requester.
//
// Parameters
//   AW       word-address width on all ports
//   TIMEOUT  WAIT cycles tolerated before error; 0 disables the timeout
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   m{0,1}_cyc_i/stb_i/we_i           master control
//   m{0,1}_be_i [3:0]                 master byte enables
//   m{0,1}_adr_i [AW-1:0]             master word address
//   m{0,1}_dat_i [31:0]               master write data
//   m{0,1}_dat_o [31:0]               read data (slave data, valid with ack)
//   m{0,1}_ack_o, m{0,1}_err_o        master termination
//   s_cyc_o/stb_o/we_o, s_be_o,
//   s_adr_o, s_dat_o                  slave request
//   s_dat_i, s_ack_i                  slave response
// ---------------------------------------------------------------------------
module wb_ram_arbiter #(
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_be_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_be_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_be_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i
);

    localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_gnt;
    logic          w_gnt_nxt;
    logic          r_last;
    logic [CW-1:0] r_tcnt;

    logic          w_req0;
    logic          w_req1;
    logic          w_gcyc;
    logic          w_busy;
    logic          w_ack;
    logic          w_tmo;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;
    assign w_gcyc = r_gnt ? m1_cyc_i : m0_cyc_i;
    assign w_busy = (r_state != IDLE);

    // A slave ack seen in IDLE belongs to an aborted transaction and is
    // never forwarded; the mandatory IDLE cycle between grants absorbs it.
    assign w_ack  = s_ack_i & w_busy & w_gcyc;

    // Ack wins over a coinciding timeout expiry.
    assign w_tmo  = (TIMEOUT != 0) && (r_state == WAIT) && (r_tcnt == TLIM)
                    && !s_ack_i && w_gcyc;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            if ((r_state == IDLE) && (w_state_nxt == ISSUE)) begin
                r_last <= w_gnt_nxt;
            end
            if ((TIMEOUT != 0) && (r_state == WAIT) && (w_state_nxt == WAIT)) begin
                r_tcnt <= r_tcnt + CW'(1);
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;

        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_be_o   = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt = ISSUE;
                    if (w_req0 && w_req1) begin
                        w_gnt_nxt = ~r_last;
                    end else begin
                        w_gnt_nxt = w_req1;
                    end
                end
            end
            ISSUE: begin
                if (s_ack_i || !w_gcyc) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (s_ack_i || !w_gcyc || w_tmo) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_busy) begin
            s_cyc_o = 1'b1;
            s_stb_o = (r_state == ISSUE);
            if (r_gnt) begin
                s_we_o  = m1_we_i;
                s_be_o  = m1_be_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end else begin
                s_we_o  = m0_we_i;
                s_be_o  = m0_be_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
        end

        m0_ack_o = w_ack & ~r_gnt;
        m1_ack_o = w_ack &  r_gnt;
        m0_err_o = w_tmo & ~r_gnt;
        m1_err_o = w_tmo &  r_gnt;
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [3:0]    m0_be  = '0;
    logic [AW-1:0] m0_adr = '0;
    logic [31:0]   m0_wd  = '0;
    logic [31:0]   m0_rd;
    logic          m0_ack, m0_err;

    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [3:0]    m1_be  = '0;
    logic [AW-1:0] m1_adr = '0;
    logic [31:0]   m1_wd  = '0;
    logic [31:0]   m1_rd;
    logic          m1_ack, m1_err;

    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_be;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_wd;
    logic [31:0]   s_rd = '0;
    logic          s_ack;

    // second instance with the timeout disabled and a slave that never acks
    logic          z_m0_cyc = 1'b0, z_m0_stb = 1'b0;
    logic          z_zero1 = 1'b0;
    logic [3:0]    z_zero4 = '0;
    logic [AW-1:0] z_zeroa = '0;
    logic [31:0]   z_zero32 = '0;
    logic [31:0]   z_m0_rd, z_m1_rd;
    logic          z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
    logic          z_s_cyc, z_s_stb, z_s_we;
    logic [3:0]    z_s_be;
    logic [AW-1:0] z_s_adr;
    logic [31:0]   z_s_wd;

    wb_ram_arbiter #(.AW(AW), .TIMEOUT(15)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_dat_o(m0_rd),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_dat_o(m1_rd),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_be_o(s_be),
        .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_rd), .s_ack_i(s_ack)
    );

    wb_ram_arbiter #(.AW(AW), .TIMEOUT(0)) u_dut_nt (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(z_m0_cyc), .m0_stb_i(z_m0_stb), .m0_we_i(z_zero1), .m0_be_i(z_zero4),
        .m0_adr_i(z_zeroa), .m0_dat_i(z_zero32), .m0_dat_o(z_m0_rd),
        .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
        .m1_cyc_i(z_zero1), .m1_stb_i(z_zero1), .m1_we_i(z_zero1), .m1_be_i(z_zero4),
        .m1_adr_i(z_zeroa), .m1_dat_i(z_zero32), .m1_dat_o(z_m1_rd),
        .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
        .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_be_o(z_s_be),
        .s_adr_o(z_s_adr), .s_dat_o(z_s_wd), .s_dat_i(z_zero32), .s_ack_i(z_zero1)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM slave model: ack arrives 'lat' cycles after the strobe (1 = registered
    // ack, 0 = never acks).
    logic [31:0] mem [0:1023];
    int unsigned lat = 1;
    logic [3:0]  scnt = '0;
    logic [31:0] wword;

    always @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
        end else if (s_cyc && s_stb) begin
            scnt <= 4'(lat);
            s_rd <= mem[s_adr];
            if (s_we) begin
                wword = mem[s_adr];
                for (int b = 0; b < 4; b++) begin
                    if (s_be[b]) wword[8*b +: 8] = s_wd[8*b +: 8];
                end
                mem[s_adr] <= wword;
            end
        end else if (scnt != 4'd0) begin
            scnt <= scnt - 4'd1;
        end
    end
    assign s_ack = (scnt == 4'd1);

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        mst;
        logic        err;
        logic        chkd;
        logic [31:0] dat;
        int unsigned c;
    } exp_t;

    exp_t q[$];

    task automatic expect_rsp(input logic mst, input logic err, input logic chkd,
                              input logic [31:0] dat, input int unsigned c);
        exp_t e;
        e.mst = mst; e.err = err; e.chkd = chkd; e.dat = dat; e.c = c;
        q.push_back(e);
    endtask

    // monitor: every ack/err presented by the DUT is matched against the queue
    logic        mon_a, mon_e;
    logic [31:0] mon_d;
    exp_t        mon_x;

    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                mon_a = (m == 0) ? m0_ack : m1_ack;
                mon_e = (m == 0) ? m0_err : m1_err;
                mon_d = (m == 0) ? m0_rd  : m1_rd;
                if (mon_a || mon_e) begin
                    chk("ack_err_exclusive", 32'(mon_a & mon_e), 32'd0);
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: master %0d ack=%b err=%b at cycle %0d, required no response",
                                 m, mon_a, mon_e, cyc);
                    end else begin
                        mon_x = q.pop_front();
                        chk("rsp_master", 32'(m), 32'(mon_x.mst));
                        chk("rsp_is_err", 32'(mon_e), 32'(mon_x.err));
                        chk("rsp_cycle", 32'(cyc), 32'(mon_x.c));
                        if (mon_x.chkd) chk("rsp_rdata", mon_d, mon_x.dat);
                    end
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick(1);
    endtask

    task automatic m0_read(input logic [AW-1:0] a);
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_adr = a;
    endtask

    task automatic m1_read(input logic [AW-1:0] a);
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_adr = a;
    endtask

    task automatic m0_drop();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    endtask

    task automatic m1_drop();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    int unsigned c0;
    int unsigned bad;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h020] = 32'h12345678;
        mem[10'h3FF] = 32'h11223344;

        // reset state
        rst = 1'b1;
        tick(3);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_s_we",  32'(s_we),  32'd0);
        chk("rst_s_be",  32'(s_be),  32'd0);
        chk("rst_s_adr", 32'(s_adr), 32'd0);
        chk("rst_m_ack", 32'({m0_ack, m1_ack}), 32'd0);
        chk("rst_m_err", 32'({m0_err, m1_err}), 32'd0);

        // both masters saturate from the first cycle after reset: m0 first,
        // then strict alternation every 3 cycles
        rst = 1'b0;
        m0_read(10'h010);
        m1_read(10'h020);
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            expect_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c0 + 2 + 6*k);
            expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, c0 + 5 + 6*k);
        end
        wait_until(c0 + 18);
        m0_drop();
        m1_drop();
        tick(2);

        // single read: one-cycle strobe, ack two cycles after request
        c0 = cyc;
        m0_read(10'h010);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c0 + 2);
        chk("single_stb_c0", 32'(s_stb), 32'd0);
        tick(1);
        chk("single_stb_c1", 32'(s_stb), 32'd1);
        chk("single_adr_c1", 32'(s_adr), 32'h010);
        tick(1);
        chk("single_stb_c2", 32'(s_stb), 32'd0);
        chk("single_cyc_c2", 32'(s_cyc), 32'd1);
        tick(1);
        m0_drop();
        chk("single_cyc_c3", 32'(s_cyc), 32'd0);

        // m1 byte write at the top address, then m0 reads it back
        c0 = cyc;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_be = 4'b0100;
        m1_adr = 10'h3FF; m1_wd = 32'h00AB0000;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 2);
        tick(1);
        chk("wr_s_adr", 32'(s_adr), 32'h3FF);
        chk("wr_s_be",  32'(s_be),  32'b0100);
        chk("wr_s_we",  32'(s_we),  32'd1);
        chk("wr_s_dat", s_wd, 32'h00AB0000);
        wait_until(c0 + 3);
        m1_drop();
        m0_read(10'h3FF);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'h11AB3344, c0 + 5);
        wait_until(c0 + 6);
        m0_drop();
        tick(1);

        // abort in WAIT: the late slave ack lands in IDLE and is dropped
        c0 = cyc;
        lat = 2;
        m0_read(10'h010);
        wait_until(c0 + 2);
        m0_drop();
        wait_until(c0 + 3);
        lat = 1;
        m1_read(10'h020);
        chk("abort_late_ack_seen", 32'(s_ack), 32'd1);
        chk("abort_m0_ack", 32'(m0_ack), 32'd0);
        chk("abort_m1_ack", 32'(m1_ack), 32'd0);
        chk("abort_s_cyc",  32'(s_cyc),  32'd0);
        expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, c0 + 5);
        wait_until(c0 + 6);
        m1_drop();
        tick(1);

        // timeout: error after 15 idle WAIT cycles, then m1 is served
        c0 = cyc;
        lat = 0;
        m0_read(10'h010);
        expect_rsp(1'b0, 1'b1, 1'b0, 32'h0, c0 + 17);
        expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, c0 + 20);
        tick(1);
        m1_read(10'h020);
        wait_until(c0 + 16);
        chk("tmo_still_waiting", 32'(s_cyc), 32'd1);
        wait_until(c0 + 18);
        m0_drop();
        lat = 1;
        wait_until(c0 + 21);
        m1_drop();
        tick(1);

        // TIMEOUT=0: the arbiter waits indefinitely
        c0 = cyc;
        z_m0_cyc = 1'b1;
        z_m0_stb = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (z_s_cyc !== 1'b1 || z_m0_err !== 1'b0 || z_m0_ack !== 1'b0) bad++;
        end
        chk("nt_wait_forever", bad, 32'd0);
        z_m0_cyc = 1'b0;
        z_m0_stb = 1'b0;
        tick(2);

        // reset in WAIT: outputs clear, first grant after reset goes to m0
        c0 = cyc;
        lat = 0;
        m0_read(10'h010);
        tick(1);
        m1_read(10'h020);
        wait_until(c0 + 3);
        chk("prerst_s_cyc", 32'(s_cyc), 32'd1);
        rst = 1'b1;
        wait_until(c0 + 4);
        rst = 1'b0;
        lat = 1;
        chk("postrst_s_cyc", 32'(s_cyc), 32'd0);
        chk("postrst_s_stb", 32'(s_stb), 32'd0);
        chk("postrst_s_ctl", 32'({s_we, s_be}), 32'd0);
        chk("postrst_s_adr", 32'(s_adr), 32'd0);
        chk("postrst_s_dat", s_wd, 32'd0);
        chk("postrst_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, c0 + 6);
        expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, c0 + 9);
        wait_until(c0 + 7);
        m0_drop();
        wait_until(c0 + 10);
        m1_drop();
        tick(3);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
